// File: rtl/psa16_sat_unit.sv
// Four-lane signed 4-bit saturating adder with a single registered output stage.
// Optional PSA16_SAT_FLAGS_EN adds a per-lane saturation flag output.
module psa16_sat_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] sum,
    output logic        out_valid
`ifdef PSA16_SAT_FLAGS_EN
    ,
    output logic [3:0]  sat_flags
`endif
);

    // Overflow can only occur when both operands share a sign that the raw sum loses.
    function automatic logic lane_ovf(input logic [3:0] x, input logic [3:0] y);
        logic [3:0] raw;
        raw = x + y;
        return (x[3] == y[3]) && (raw[3] != x[3]);
    endfunction

    function automatic logic [3:0] sat_lane(input logic [3:0] x, input logic [3:0] y);
        logic [3:0] raw;
        raw = x + y;
        if (lane_ovf(x, y)) begin
            sat_lane = x[3] ? 4'b1000 : 4'b0111;
        end else begin
            sat_lane = raw;
        end
    endfunction

    logic [15:0] w_sum;
    logic [15:0] r_sum;
    logic        r_out_valid;

    // Lane-wise saturating sum; lanes never exchange carries.
    always_comb begin
        w_sum = 16'h0000;
        for (int i = 0; i < 4; i++) begin
            w_sum[4*i +: 4] = sat_lane(a[4*i +: 4], b[4*i +: 4]);
        end
    end

    // Result and valid registers; reset discards any in-flight operation.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sum       <= 16'h0000;
            r_out_valid <= 1'b0;
        end else if (in_valid) begin
            r_sum       <= w_sum;
            r_out_valid <= 1'b1;
        end else begin
            r_out_valid <= 1'b0;
        end
    end

    assign sum       = r_sum;
    assign out_valid = r_out_valid;

`ifdef PSA16_SAT_FLAGS_EN
    logic [3:0] w_sat;
    logic [3:0] r_sat_flags;

    // Per-lane saturation indication for the same operands as w_sum.
    always_comb begin
        w_sat = 4'h0;
        for (int i = 0; i < 4; i++) begin
            w_sat[i] = lane_ovf(a[4*i +: 4], b[4*i +: 4]);
        end
    end

    // Flags load alongside sum and hold when no operands arrive.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sat_flags <= 4'h0;
        end else if (in_valid) begin
            r_sat_flags <= w_sat;
        end else begin
            r_sat_flags <= r_sat_flags;
        end
    end

    assign sat_flags = r_sat_flags;
`endif

endmodule

// File: tb/tb_psa16_sat_unit.sv
// Directed and random checks of the four-lane saturating adder.
module tb_psa16_sat_unit;
    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] sum;
    logic        out_valid;
`ifdef PSA16_SAT_FLAGS_EN
    logic [3:0]  sat_flags;
`endif

    int n_cmp = 0;
    int n_err = 0;

    psa16_sat_unit dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .sum       (sum),
        .out_valid (out_valid)
`ifdef PSA16_SAT_FLAGS_EN
        ,
        .sat_flags (sat_flags)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: integer add then clamp into [-8, 7].
    function automatic logic [15:0] ref_sum(input logic [15:0] x, input logic [15:0] y);
        logic [15:0] res;
        logic [31:0] t;
        int s;
        res = 16'h0000;
        for (int i = 0; i < 4; i++) begin
            s = int'($signed(x[4*i +: 4])) + int'($signed(y[4*i +: 4]));
            if (s > 7) s = 7;
            if (s < -8) s = -8;
            t = s;
            res[4*i +: 4] = t[3:0];
        end
        return res;
    endfunction

    function automatic logic [3:0] ref_flags(input logic [15:0] x, input logic [15:0] y);
        logic [3:0] f;
        int s;
        f = 4'h0;
        for (int i = 0; i < 4; i++) begin
            s = int'($signed(x[4*i +: 4])) + int'($signed(y[4*i +: 4]));
            f[i] = (s > 7) || (s < -8);
        end
        return f;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic v, input logic [15:0] x, input logic [15:0] y);
        rst = r; in_valid = v; a = x; b = y;
    endtask

    task automatic test_reset;
        drive(1'b1, 1'b1, 16'h1234, 16'h1111);
        tick();
        n_cmp++;
        if (sum !== 16'h0000) begin n_err++; $display("FAIL reset_sum actual=%h required=%h", sum, 16'h0000); end
        n_cmp++;
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid actual=%b required=0", out_valid); end
`ifdef PSA16_SAT_FLAGS_EN
        n_cmp++;
        if (sat_flags !== 4'h0) begin n_err++; $display("FAIL reset_flags actual=%h required=0", sat_flags); end
`endif
    endtask

    task automatic test_vectors;
        logic [15:0] va [8] = '{16'h1234, 16'h7777, 16'h8888, 16'h5A3C, 16'h7F00, 16'h7878, 16'h8F8F, 16'h0F07};
        logic [15:0] vb [8] = '{16'h1111, 16'h1111, 16'h8888, 16'h3C5A, 16'h9101, 16'h8787, 16'hF8F8, 16'h0F01};
        logic [15:0] es [8] = '{16'h2345, 16'h7777, 16'h8888, 16'h7878, 16'h0001, 16'hFFFF, 16'h8888, 16'h0E07};
        logic [3:0]  ef [8] = '{4'h0, 4'hF, 4'hF, 4'hF, 4'h0, 4'h0, 4'hF, 4'h1};
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 1'b1, va[i], vb[i]);
            tick();
            n_cmp++;
            if (sum !== es[i]) begin n_err++; $display("FAIL vec%0d_sum actual=%h required=%h", i, sum, es[i]); end
            n_cmp++;
            if (out_valid !== 1'b1) begin n_err++; $display("FAIL vec%0d_valid actual=%b required=1", i, out_valid); end
`ifdef PSA16_SAT_FLAGS_EN
            n_cmp++;
            if (sat_flags !== ef[i]) begin n_err++; $display("FAIL vec%0d_flags actual=%h required=%h", i, sat_flags, ef[i]); end
`else
            if (ef[i] > 4'hF) $display("unreachable");
`endif
        end
    endtask

    task automatic test_hold;
        drive(1'b0, 1'b1, 16'h0F07, 16'h0F01);
        tick();
        drive(1'b0, 1'b0, 16'h1111, 16'h2222);
        tick();
        n_cmp++;
        if (sum !== 16'h0E07) begin n_err++; $display("FAIL hold_sum actual=%h required=%h", sum, 16'h0E07); end
        n_cmp++;
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL hold_valid actual=%b required=0", out_valid); end
`ifdef PSA16_SAT_FLAGS_EN
        n_cmp++;
        if (sat_flags !== 4'h1) begin n_err++; $display("FAIL hold_flags actual=%h required=1", sat_flags); end
`endif
        tick();
        n_cmp++;
        if (sum !== 16'h0E07) begin n_err++; $display("FAIL hold2_sum actual=%h required=%h", sum, 16'h0E07); end
    endtask

    task automatic test_midstream_reset;
        drive(1'b0, 1'b1, 16'h1234, 16'h1111);
        tick();
        drive(1'b1, 1'b1, 16'h7777, 16'h1111);
        tick();
        n_cmp++;
        if (sum !== 16'h0000) begin n_err++; $display("FAIL midrst_sum actual=%h required=0000", sum); end
        n_cmp++;
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL midrst_valid actual=%b required=0", out_valid); end
        drive(1'b0, 1'b0, 16'h0000, 16'h0000);
        tick();
    endtask

    task automatic test_back_to_back;
        logic [15:0] x;
        logic [15:0] y;
        logic [15:0] e;
        for (int i = 0; i < 65535; i++) begin
            x = 16'($urandom);
            y = 16'($urandom);
            drive(1'b0, 1'b1, x, y);
            tick();
            e = ref_sum(x, y);
            n_cmp++;
            if (sum !== e || out_valid !== 1'b1) begin
                n_err++;
                $display("FAIL rand%0d a=%h b=%h actual=%h/%b required=%h/1", i, x, y, sum, out_valid, e);
            end
`ifdef PSA16_SAT_FLAGS_EN
            n_cmp++;
            if (sat_flags !== ref_flags(x, y)) begin
                n_err++;
                $display("FAIL rand%0d_flags actual=%h required=%h", i, sat_flags, ref_flags(x, y));
            end
`endif
        end
        drive(1'b0, 1'b0, 16'h0000, 16'h0000);
        tick();
        n_cmp++;
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL b2b_tail_valid actual=%b required=0", out_valid); end
    endtask

    initial begin
        drive(1'b1, 1'b0, 16'h0000, 16'h0000);
        test_reset();
        test_vectors();
        test_hold();
        test_midstream_reset();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/psa16_sat_unit.md
Name:
psa16_sat_unit

Overview:
- Parallel sub-word adder (PADDSB-style) for a 16-bit datapath.
- Treats each 16-bit operand as four independent signed 4-bit lanes and adds lane-wise with signed saturation.
- No carry propagates between lanes.
- Sits in the execute stage beside the main ALU; the result is registered once, giving a 1-cycle latency.

Parameters:
- None. Lane width is fixed at 4 bits and lane count at 4.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operands a/b valid this cycle
- a  input  16  operand A; lane i = a[4i+3:4i], signed two's complement
- b  input  16  operand B; same lane layout as a
- sum  output  16  registered saturated lane-wise sum; lane i = sum[4i+3:4i]
- out_valid  output  1  sum holds a result computed from the operands accepted on the previous cycle

Behaviour:
- Reset (rst=1 at a rising edge): sum <= 16'h0000, out_valid <= 0. Reset takes priority over in_valid.
- Per lane i, computed combinationally: raw = a_i + b_i, truncated to 4 bits.
  - Positive overflow: a_i[3]=0, b_i[3]=0, raw[3]=1 -> lane = 4'b0111 (+7).
  - Negative overflow: a_i[3]=1, b_i[3]=1, raw[3]=0 -> lane = 4'b1000 (-8). Includes -8 + -8, where raw = 0.
  - Otherwise lane = raw. Mixed-sign operands never saturate.
- Lanes are fully independent; a carry out of lane i is discarded.
- Registering:
  - On a rising edge with rst=0 and in_valid=1: sum <= packed lane results, out_valid <= 1.
  - rst=0 and in_valid=0: sum holds its previous value, out_valid <= 0.
- Latency: exactly 1 cycle. Throughput: one operation per cycle; back-to-back in_valid is supported with no stalls.
- No handshake or back-pressure: the consumer must take sum in the cycle out_valid=1.
- Reset asserted mid-stream discards the in-flight result; out_valid=0 on the following cycle.
- No X propagation: outputs are defined from the first edge on which rst=1.

Optional Feature:
- Macro: PSA16_SAT_FLAGS_EN.
- Defined: adds output port sat_flags [3:0]. Bit i = 1 when lane i saturated (either direction) for the registered result. It loads together with sum, resets to 4'h0, and holds when in_valid=0.
- Undefined: the sat_flags port and its logic are absent. sum and out_valid behaviour is identical in both builds.

Test Plan:
- Basic add, no overflow: a=16'h1234, b=16'h1111, in_valid=1 -> next cycle sum=16'h2345, out_valid=1; sat_flags=4'h0 when the macro is defined.
- Positive saturation: a=16'h7777, b=16'h1111 -> sum=16'h7777, sat_flags=4'hF.
- Negative saturation including -8+-8: a=16'h8888, b=16'h8888 -> sum=16'h8888, sat_flags=4'hF.
- Mixed per-lane saturation: a=16'h5A3C, b=16'h3C5A -> sum=16'h7878, sat_flags=4'hF. Mixed signs with no saturation: a=16'h7F00, b=16'h9101 -> sum=16'h0001, sat_flags=4'h0.
- Reset and hold:
  - Apply rst=1 together with in_valid=1, a=16'h1234 -> next cycle sum=16'h0000, out_valid=0.
  - Then in_valid=0 after a valid op -> sum holds its value, out_valid=0.
- Random regression: 65535 back-to-back random a/b vectors, in_valid=1 every cycle. Each cycle's sum must equal the per-lane saturating reference model applied to the previous cycle's operands.
